vrf_banked_xbar: RTL and testbench

Banked, byte-writable vector register file slice for one lane, with a backpressured read crossbar to the operand queues. Each bank holds single-ported storage and a one-deep read hold register. Per-output round-robin arbitration routes held read data to `NrOutputs` valid/ready operand channels. Banks stall only when their own hold register cannot drain, so a slow operand queue never drops data.

---
 rtl/vrf_banked_xbar.sv | 152 +++++++++++++++
 tb/tb_vrf_banked_xbar.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_banked_xbar.sv
// rtl/vrf_banked_xbar.sv - banked byte-writable VRF slice with round-robin operand crossbar (optional VRF_PARITY_EN)
module vrf_banked_xbar #(
    parameter int unsigned NrBanks   = 8,
    parameter int unsigned NumWords  = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NrOutputs = 4,
    localparam int unsigned StrbWidth = DataWidth / 8,
    localparam int unsigned AddrW     = $clog2(NumWords),
    localparam int unsigned TgtW      = (NrOutputs > 1) ? $clog2(NrOutputs) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrBanks-1:0]                   req_i,
    output logic [NrBanks-1:0]                   gnt_o,
    input  logic [NrBanks-1:0][AddrW-1:0]        addr_i,
    input  logic [NrBanks-1:0]                   wen_i,
    input  logic [NrBanks-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NrBanks-1:0][StrbWidth-1:0]    be_i,
    input  logic [NrBanks-1:0][TgtW-1:0]         tgt_i,
    output logic [NrOutputs-1:0][DataWidth-1:0]  operand_o,
    output logic [NrOutputs-1:0]                 operand_valid_o,
    input  logic [NrOutputs-1:0]                 operand_ready_i,
    output logic [NrBanks-1:0]                   parity_err_o
);

    localparam int unsigned BankW = (NrBanks > 1) ? $clog2(NrBanks) : 1;

    logic [DataWidth-1:0]               mem_q [NrBanks][NumWords];
    logic [NrBanks-1:0][DataWidth-1:0]  rd_word;
    logic [NrBanks-1:0]                 gnt, hold_pop, hold_load;
    logic [NrBanks-1:0]                 hold_valid_q;
    logic [NrBanks-1:0][DataWidth-1:0]  hold_data_q;
    logic [NrBanks-1:0][TgtW-1:0]       hold_tgt_q;
    logic [NrOutputs-1:0][BankW-1:0]    rr_ptr_q, lock_bank_q, sel;
    logic [NrOutputs-1:0]               lock_q, found, hs;

    // Byte-masked writes into per-bank single-ported storage (contents are not reset)
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NrBanks; b++)
            for (int s = 0; s < StrbWidth; s++)
                if (req_i[b] && wen_i[b] && be_i[b][s])
                    mem_q[b][addr_i[b]][s*8 +: 8] <= wdata_i[b][s*8 +: 8];
    end

    // Crossbar selection: a locked output keeps its bank, otherwise search round-robin from rr_ptr
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NrOutputs; o++) begin
            sel[o]   = lock_bank_q[o];
            found[o] = lock_q[o];
            if (!lock_q[o]) begin
                for (int i = 0; i < NrBanks; i++) begin
                    idx = (int'(rr_ptr_q[o]) + i) % NrBanks;
                    if (!found[o] && hold_valid_q[idx] && int'(hold_tgt_q[idx]) == o) begin
                        found[o] = 1'b1;
                        sel[o]   = BankW'(idx);
                    end
                end
            end
            hs[o]              = found[o] & operand_ready_i[o];
            operand_valid_o[o] = found[o];
            operand_o[o]       = found[o] ? hold_data_q[sel[o]] : '0;
        end
    end

    // Grants: writes always proceed; reads need an empty or draining hold register
    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            hold_pop[b] = 1'b0;
            for (int o = 0; o < NrOutputs; o++)
                if (hs[o] && sel[o] == BankW'(b)) hold_pop[b] = 1'b1;
            gnt[b]       = wen_i[b] | ~hold_valid_q[b] | hold_pop[b];
            hold_load[b] = req_i[b] & ~wen_i[b] & gnt[b] & (32'(tgt_i[b]) < NrOutputs);
            rd_word[b]   = mem_q[b][addr_i[b]];
        end
    end

    assign gnt_o = gnt;

    // Hold registers: a load wins over a same-cycle pop so back-to-back reads stream
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= '0;
            hold_data_q  <= '0;
            hold_tgt_q   <= '0;
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                if (hold_load[b]) begin
                    hold_valid_q[b] <= 1'b1;
                    hold_data_q[b]  <= rd_word[b];
                    hold_tgt_q[b]   <= tgt_i[b];
                end else if (hold_pop[b]) begin
                    hold_valid_q[b] <= 1'b0;
                end
            end
        end
    end

    // Per-output lock and round-robin pointer; pointer moves past the winner on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_q      <= '0;
            lock_bank_q <= '0;
        end else begin
            for (int o = 0; o < NrOutputs; o++) begin
                if (hs[o]) begin
                    lock_q[o]   <= 1'b0;
                    rr_ptr_q[o] <= (sel[o] == BankW'(NrBanks - 1)) ? '0 : sel[o] + 1'b1;
                end else if (found[o]) begin
                    lock_q[o]      <= 1'b1;
                    lock_bank_q[o] <= sel[o];
                end
            end
        end
    end

`ifdef VRF_PARITY_EN
    logic [StrbWidth-1:0] par_q [NrBanks][NumWords];
    logic [NrBanks-1:0]   rd_perr;
    logic [NrBanks-1:0]   perr_q;

    // Even parity per byte, refreshed only for the bytes actually written
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NrBanks; b++)
            for (int s = 0; s < StrbWidth; s++)
                if (req_i[b] && wen_i[b] && be_i[b][s])
                    par_q[b][addr_i[b]][s] <= ^wdata_i[b][s*8 +: 8];
    end

    // Check every byte of the word being read
    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            rd_perr[b] = 1'b0;
            for (int s = 0; s < StrbWidth; s++)
                if (par_q[b][addr_i[b]][s] != ^rd_word[b][s*8 +: 8]) rd_perr[b] = 1'b1;
        end
    end

    // Error pulse lines up with the cycle the hold register shows the data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perr_q <= '0;
        else         perr_q <= hold_load & rd_perr;
    end

    assign parity_err_o = perr_q;
`else
    assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_vrf_banked_xbar.sv
// tb/tb_vrf_banked_xbar.sv - directed table-driven bench for vrf_banked_xbar
module tb_vrf_banked_xbar;

    localparam int NB = 8;
    localparam int NW = 64;
    localparam int DW = 64;
    localparam int NO = 3;
    localparam int AW = 6;
    localparam int TW = 2;
    localparam int SW = 8;

    logic                    clk, rst_n;
    logic [NB-1:0]           req, gnt, wen, perr;
    logic [NB-1:0][AW-1:0]   addr;
    logic [NB-1:0][DW-1:0]   wdata;
    logic [NB-1:0][SW-1:0]   be;
    logic [NB-1:0][TW-1:0]   tgt;
    logic [NO-1:0][DW-1:0]   operand;
    logic [NO-1:0]           ovalid, oready;

    int checks   = 0;
    int failures = 0;

    vrf_banked_xbar #(.NrBanks(NB), .NumWords(NW), .DataWidth(DW), .NrOutputs(NO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .tgt_i(tgt), .operand_o(operand),
        .operand_valid_o(ovalid), .operand_ready_i(oready), .parity_err_o(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          bank;
        int          addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        int          tgt;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_write(input int b, input int a, input logic [63:0] d, input logic [7:0] m);
        req[b] = 1'b1; wen[b] = 1'b1; addr[b] = AW'(a); wdata[b] = d; be[b] = m;
    endtask

    task automatic start_read(input int b, input int a, input int t);
        req[b] = 1'b1; wen[b] = 1'b0; addr[b] = AW'(a); tgt[b] = TW'(t);
    endtask

    logic [63:0] cont_exp [3];
    logic [63:0] x_word, y_word;

    initial begin
        vecs[0] = '{0, 5,  64'h0123_4567_89AB_CDEF, 8'hFF, 2, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{1, 7,  64'h1111_1111_1111_1111, 8'hFF, 0, 64'h1111_1111_1111_1111};
        vecs[2] = '{1, 7,  64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1, 64'h1111_1111_FFFF_FFFF};
        vecs[3] = '{1, 7,  64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 2, 64'h1111_1111_FFFF_FFFF};
        vecs[4] = '{7, 63, 64'hA5A5_5A5A_0000_FFFF, 8'hFF, 1, 64'hA5A5_5A5A_0000_FFFF};
        vecs[5] = '{7, 63, 64'h0000_0000_1234_0000, 8'h04, 0, 64'hA5A5_5A5A_0034_FFFF};

        rst_n = 1'b0; req = '0; wen = '0; addr = '0; wdata = '0; be = '0; tgt = '0;
        oready = '1;
        @(negedge clk);
        chk("rst_valid", 64'(ovalid), 64'h0);
        for (int o = 0; o < NO; o++) chk("rst_operand", operand[o], 64'h0);
        chk("rst_perr", 64'(perr), 64'h0);
        chk("rst_gnt", 64'(gnt), 64'hFF);
        step();
        rst_n = 1'b1;
        step();

        // write then read-back through the crossbar, one row at a time
        for (int i = 0; i < 6; i++) begin
            start_write(vecs[i].bank, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            @(negedge clk);
            chk($sformatf("v%0d_wgnt", i), 64'(gnt[vecs[i].bank]), 64'h1);
            step();
            start_read(vecs[i].bank, vecs[i].addr, vecs[i].tgt);
            @(negedge clk);
            chk($sformatf("v%0d_rgnt", i), 64'(gnt[vecs[i].bank]), 64'h1);
            chk($sformatf("v%0d_novalid_early", i), 64'(ovalid), 64'h0);
            step();
            req = '0;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(ovalid), 64'(1 << vecs[i].tgt));
            chk($sformatf("v%0d_data", i), operand[vecs[i].tgt], vecs[i].exp);
            chk($sformatf("v%0d_perr", i), 64'(perr), 64'h0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), 64'(ovalid), 64'h0);
            step();
        end

        // backpressure on output 1
        x_word = 64'hCAFE_0000_1234_5678;
        y_word = 64'h0BAD_F00D_8765_4321;
        oready[1] = 1'b0;
        start_write(3, 2, x_word, 8'hFF);
        step();
        start_read(3, 2, 1);
        @(negedge clk);
        chk("bp_first_gnt", 64'(gnt[3]), 64'h1);
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stall_gnt%0d", c), 64'(gnt[3]), 64'h0);
            chk($sformatf("bp_stall_valid%0d", c), 64'(ovalid[1]), 64'h1);
            chk($sformatf("bp_stall_data%0d", c), operand[1], x_word);
            step();
        end
        start_write(3, 4, y_word, 8'hFF);
        @(negedge clk);
        chk("bp_write_gnt", 64'(gnt[3]), 64'h1);
        step();
        start_read(3, 4, 1);
        oready[1] = 1'b1;
        @(negedge clk);
        chk("bp_release_gnt", 64'(gnt[3]), 64'h1);
        chk("bp_release_data", operand[1], x_word);
        step();
        req = '0;
        @(negedge clk);
        chk("bp_next_valid", 64'(ovalid[1]), 64'h1);
        chk("bp_next_data", operand[1], y_word);
        step();
        @(negedge clk);
        chk("bp_done", 64'(ovalid), 64'h0);
        step();

        // contention: banks 0,1,2 all target output 0
        start_write(2, 9, 64'h2222_3333_4444_5555, 8'hFF);
        step();
        req = '0;
        cont_exp[0] = 64'h0123_4567_89AB_CDEF;
        cont_exp[1] = 64'h1111_1111_FFFF_FFFF;
        cont_exp[2] = 64'h2222_3333_4444_5555;
        for (int r = 0; r < 2; r++) begin
            start_read(0, 5, 0);
            start_read(1, 7, 0);
            start_read(2, 9, 0);
            @(negedge clk);
            chk($sformatf("ct%0d_gnt", r), 64'(gnt[2:0]), 64'h7);
            step();
            req = '0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("ct%0d_valid%0d", r, k), 64'(ovalid[0]), 64'h1);
                chk($sformatf("ct%0d_order%0d", r, k), operand[0], cont_exp[k]);
                step();
            end
            @(negedge clk);
            chk($sformatf("ct%0d_done", r), 64'(ovalid), 64'h0);
            step();
        end

        // invalid target is granted and dropped
        start_read(5, 0, NO);
        @(negedge clk);
        chk("inv_gnt", 64'(gnt[5]), 64'h1);
        step();
        start_read(5, 0, NO);
        @(negedge clk);
        chk("inv_novalid", 64'(ovalid), 64'h0);
        chk("inv_regnt", 64'(gnt[5]), 64'h1);
        step();
        req = '0;
        @(negedge clk);
        chk("inv_novalid2", 64'(ovalid), 64'h0);
        step();

`ifdef VRF_PARITY_EN
        start_write(2, 11, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF);
        step();
        req = '0;
        dut.mem_q[2][11][9] = ~dut.mem_q[2][11][9];
        start_read(2, 11, 0);
        @(negedge clk);
        chk("par_gnt", 64'(perr), 64'h0);
        step();
        req = '0;
        @(negedge clk);
        chk("par_pulse", 64'(perr), 64'h04);
        chk("par_data", operand[0], 64'h0F0F_0F0F_0F0F_0D0F);
        step();
        @(negedge clk);
        chk("par_one_cycle", 64'(perr), 64'h0);
        step();
`else
        chk("par_tied_low", 64'(perr), 64'h0);
`endif

        // reset while a read is held
        oready[0] = 1'b0;
        start_read(6, 1, 0);
        step();
        req = '0;
        @(negedge clk);
        chk("mrst_held", 64'(ovalid[0]), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(ovalid), 64'h0);
        chk("mrst_operand", operand[0], 64'h0);
        step();
        rst_n = 1'b1;
        oready = '1;
        @(negedge clk);
        chk("mrst_after_valid", 64'(ovalid), 64'h0);
        chk("mrst_after_gnt", 64'(gnt), 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
